adder_share_sched: RTL and testbench

Round-robin scheduler that time-multiplexes one registered signed adder among `N_REQ` requesters in the spike-feature datapath. Each requester offers an operand pair with a valid/ready handshake. The scheduler grants at most one pair per cycle, drives the shared adder's operand ports, and tracks in-flight grants through a tag pipeline matched to the adder latency. It then returns each sum to the requester that issued it. The block sits between the decision-tree node evaluators and the single shared adder instance.

---
 rtl/adder_share_sched_if.sv | 46 ++++
 rtl/adder_share_sched.sv | 115 +++++++++++
 tb/tb_adder_share_sched.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_sched_if.sv
// ---------------------------------------------------------------------------
// adder_share_sched_if
//   Bundle between the decision-tree node evaluators, the shared-adder
//   scheduler and the single shared adder instance.
//
//   Signals:
//     enable     : grant enable (1 = new grants allowed)
//     req_valid  : per-requester operand offer
//     req_a/b    : flattened signed operands, requester i at [i*IN_WIDTH +: IN_WIDTH]
//     req_ready  : per-requester grant (one-hot or zero)
//     add_a/b    : operands to the shared adder
//     add_y      : shared adder result (IN_WIDTH+1 bits)
//     rsp_valid  : per-requester response strobe (one-hot or zero)
//     rsp_y      : signed sum returned to the owner flagged in rsp_valid
//     busy       : at least one grant in flight
//
//   Modports:
//     slave  : the scheduler
//     master : requesters plus shared adder (the environment)
// ---------------------------------------------------------------------------
interface adder_share_sched_if #(
  parameter int IN_WIDTH = 11,
  parameter int N_REQ    = 4
);
  logic                      enable;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*IN_WIDTH-1:0] req_a;
  logic [N_REQ*IN_WIDTH-1:0] req_b;
  logic [N_REQ-1:0]          req_ready;
  logic [IN_WIDTH-1:0]       add_a;
  logic [IN_WIDTH-1:0]       add_b;
  logic [IN_WIDTH:0]         add_y;
  logic [N_REQ-1:0]          rsp_valid;
  logic [IN_WIDTH:0]         rsp_y;
  logic                      busy;

  modport slave (
    input  enable, req_valid, req_a, req_b, add_y,
    output req_ready, add_a, add_b, rsp_valid, rsp_y, busy
  );

  modport master (
    output enable, req_valid, req_a, req_b, add_y,
    input  req_ready, add_a, add_b, rsp_valid, rsp_y, busy
  );
endinterface

// File: rtl/adder_share_sched.sv
// ---------------------------------------------------------------------------
// adder_share_sched
//   Round-robin scheduler time-multiplexing one registered signed adder
//   among N_REQ requesters. At most one operand pair is granted per cycle;
//   the granted pair is steered onto the adder ports combinationally so the
//   adder captures it on the grant edge. A tag pipeline of depth ADD_LAT
//   follows each grant through the adder and steers add_y back to the
//   requester that issued it.
//
//   Ports:
//     clk   : clock
//     reset : synchronous, active-high reset (also resets the shared adder)
//     bus   : adder_share_sched_if.slave (handshake, adder and response bus)
//
//   Parameters:
//     IN_WIDTH : signed operand width (sum is IN_WIDTH+1 bits)
//     N_REQ    : number of requesters, 2..16
//     ADD_LAT  : shared adder latency in cycles, 1..4
// ---------------------------------------------------------------------------
module adder_share_sched #(
  parameter int IN_WIDTH = 11,
  parameter int N_REQ    = 4,
  parameter int ADD_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  adder_share_sched_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  logic [IDX_W-1:0] last;        // most recently granted requester
  logic             grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  tag_t             tag_q [ADD_LAT];
  logic [ADD_LAT-1:0] stage_valid;

  // Round-robin search starting just after the last grant, wrapping modulo
  // N_REQ; the first valid requester wins.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment so no path leaves it unassigned (which would infer a latch).
    grant     = 1'b0;
    grant_idx = last;
    cand      = last;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % N_REQ);
      if (!grant && bus.req_valid[cand]) begin
        grant     = 1'b1;
        grant_idx = cand;
      end
    end
    if (reset || !bus.enable) begin
      grant = 1'b0;
    end
  end

  // Grant vector and operand mux; idle ports sit at zero.
  always_comb begin
    bus.req_ready = '0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    if (grant) begin
      bus.req_ready[grant_idx] = 1'b1;
      bus.add_a = bus.req_a[grant_idx*IN_WIDTH +: IN_WIDTH];
      bus.add_b = bus.req_b[grant_idx*IN_WIDTH +: IN_WIDTH];
    end
  end

  // Arbitration pointer and tag pipeline. Stage 0 loads on every edge, so a
  // bubble (valid=0) follows a no-grant cycle through the adder latency.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of its predecessor.
    if (reset) begin
      last <= IDX_W'(N_REQ - 1);
      // NOTE: the tag array is reset because its valid bits gate rsp_valid;
      // stale tags must never surface after reset.
      for (int i = 0; i < ADD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (grant) begin
        last <= grant_idx;
      end
      tag_q[0] <= '{valid: grant, idx: grant_idx};
      for (int i = 1; i < ADD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  for (genvar g = 0; g < ADD_LAT; g++) begin : g_stage_valid
    assign stage_valid[g] = tag_q[g].valid;
  end

  assign bus.busy = |stage_valid;

  // Response steering: the tag leaving the last stage lines up with add_y.
  always_comb begin
    bus.rsp_valid = '0;
    if (tag_q[ADD_LAT-1].valid) begin
      bus.rsp_valid[tag_q[ADD_LAT-1].idx] = 1'b1;
    end
  end

  assign bus.rsp_y = bus.add_y;

endmodule

// File: tb/tb_adder_share_sched.sv
// ---------------------------------------------------------------------------
// tb_adder_share_sched
//   Two schedulers (ADD_LAT=1 and ADD_LAT=3) share the same requester
//   stimulus; each drives its own behavioural registered adder. A reference
//   model (round-robin pointer plus per-latency queues of expected results)
//   predicts grants, operands, responses and busy every cycle. A vector table
//   and hand-written sequences add fixed-value checks for the corner cases.
// ---------------------------------------------------------------------------
module tb_adder_share_sched;

  localparam int W = 11;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;

  always #5 clk = ~clk;

  adder_share_sched_if #(.IN_WIDTH(W), .N_REQ(N)) if1 ();
  adder_share_sched_if #(.IN_WIDTH(W), .N_REQ(N)) if3 ();

  assign if1.enable    = enable;
  assign if1.req_valid = req_valid;
  assign if1.req_a     = req_a;
  assign if1.req_b     = req_b;
  assign if3.enable    = enable;
  assign if3.req_valid = req_valid;
  assign if3.req_a     = req_a;
  assign if3.req_b     = req_b;

  adder_share_sched #(.IN_WIDTH(W), .N_REQ(N), .ADD_LAT(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  adder_share_sched #(.IN_WIDTH(W), .N_REQ(N), .ADD_LAT(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  // Behavioural shared adders, reset on the same reset.
  logic signed [W:0] y1_q;
  logic signed [W:0] y3_q [3];

  always_ff @(posedge clk) begin
    if (reset) begin
      y1_q <= '0;
      for (int i = 0; i < 3; i++) y3_q[i] <= '0;
    end else begin
      y1_q    <= $signed({if1.add_a[W-1], if1.add_a}) + $signed({if1.add_b[W-1], if1.add_b});
      y3_q[0] <= $signed({if3.add_a[W-1], if3.add_a}) + $signed({if3.add_b[W-1], if3.add_b});
      y3_q[1] <= y3_q[0];
      y3_q[2] <= y3_q[1];
    end
  end

  assign if1.add_y = y1_q;
  assign if3.add_y = y3_q[2];

  // ------------------------------------------------------------------
  // Reference model and bookkeeping
  // ------------------------------------------------------------------
  typedef struct {
    int due;
    int owner;
    int sum;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   last_m = N - 1;
  int   cur    = 0;
  int   errors = 0;
  int   checks = 0;

  logic [N-1:0]      obs_ready1, obs_ready3, obs_rsp1, obs_rsp3;
  logic signed [W:0] obs_y1;
  logic              obs_busy1, obs_busy3;
  logic [W-1:0]      obs_adda1, obs_addb1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int slice(input logic [N*W-1:0] v, input int i);
    logic signed [W-1:0] s;
    s = v[i*W +: W];
    return int'(s);
  endfunction

  // First valid requester after the last grant, wrapping; -1 for none.
  function automatic int model_grant();
    if (reset || !enable) return -1;
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(last_m + k) % N]) return (last_m + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: compare all outputs mid-cycle, then advance the model
  // at the edge. Inputs are changed by the caller after this returns.
  task automatic step();
    int g, ea, eb, ey1, ey3;
    logic [N-1:0] erv1, erv3;
    logic eb1, eb3;
    @(negedge clk);
    g  = model_grant();
    ea = (g < 0) ? 0 : slice(req_a, g);
    eb = (g < 0) ? 0 : slice(req_b, g);

    obs_ready1 = if1.req_ready;  obs_ready3 = if3.req_ready;
    obs_rsp1   = if1.rsp_valid;  obs_rsp3   = if3.rsp_valid;
    obs_y1     = if1.rsp_y;
    obs_busy1  = if1.busy;       obs_busy3  = if3.busy;
    obs_adda1  = if1.add_a;      obs_addb1  = if1.add_b;

    check("req_ready_l1", if1.req_ready, (g < 0) ? 0 : (1 << g));
    check("req_ready_l3", if3.req_ready, (g < 0) ? 0 : (1 << g));
    check("add_a_l1", $signed(if1.add_a), ea);
    check("add_b_l1", $signed(if1.add_b), eb);
    check("add_a_l3", $signed(if3.add_a), ea);
    check("add_b_l3", $signed(if3.add_b), eb);

    erv1 = '0; ey1 = 0; eb1 = (q1.size() > 0);
    if (q1.size() > 0 && q1[0].due == cur) begin
      erv1[q1[0].owner] = 1'b1;
      ey1 = q1[0].sum;
    end
    check("rsp_valid_l1", if1.rsp_valid, erv1);
    check("busy_l1", if1.busy, eb1);
    if (erv1 != 0) begin
      check("rsp_y_l1", $signed(if1.rsp_y), ey1);
      void'(q1.pop_front());
    end

    erv3 = '0; ey3 = 0; eb3 = (q3.size() > 0);
    if (q3.size() > 0 && q3[0].due == cur) begin
      erv3[q3[0].owner] = 1'b1;
      ey3 = q3[0].sum;
    end
    check("rsp_valid_l3", if3.rsp_valid, erv3);
    check("busy_l3", if3.busy, eb3);
    if (erv3 != 0) begin
      check("rsp_y_l3", $signed(if3.rsp_y), ey3);
      void'(q3.pop_front());
    end

    @(posedge clk);
    if (reset) begin
      q1.delete();
      q3.delete();
      last_m = N - 1;
    end else if (g >= 0) begin
      last_m = g;
      q1.push_back('{due: cur + 1, owner: g, sum: ea + eb});
      q3.push_back('{due: cur + 3, owner: g, sum: ea + eb});
    end
    cur++;
    #1;
  endtask

  // ------------------------------------------------------------------
  // Vector table (expectations for the ADD_LAT=1 instance)
  // ------------------------------------------------------------------
  typedef struct {
    logic         rst;
    logic         en;
    logic [N-1:0] valid;
    int           a;
    int           b;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rsp;
    int           exp_y;
  } vec_t;

  vec_t vecs [19];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_rsp, last_rsp, busy_fall;

    vecs[0]  = '{1'b1, 1'b1, 4'b0000,     0,     0, 4'b0000, 4'b0000,     0};
    vecs[1]  = '{1'b1, 1'b1, 4'b1111,     0,     0, 4'b0000, 4'b0000,     0};
    vecs[2]  = '{1'b0, 1'b1, 4'b1111,     1,     2, 4'b0001, 4'b0000,     0};
    vecs[3]  = '{1'b0, 1'b1, 4'b1111,     3,     4, 4'b0010, 4'b0001,     3};
    vecs[4]  = '{1'b0, 1'b1, 4'b1111,     5,     6, 4'b0100, 4'b0010,     7};
    vecs[5]  = '{1'b0, 1'b1, 4'b1111,     7,     8, 4'b1000, 4'b0100,    11};
    vecs[6]  = '{1'b0, 1'b1, 4'b1111,     9,    10, 4'b0001, 4'b1000,    15};
    vecs[7]  = '{1'b0, 1'b1, 4'b0100,     5,    -3, 4'b0100, 4'b0001,    19};
    vecs[8]  = '{1'b0, 1'b1, 4'b0100,  1023,  1023, 4'b0100, 4'b0100,     2};
    vecs[9]  = '{1'b0, 1'b1, 4'b0100, -1024, -1024, 4'b0100, 4'b0100,  2046};
    vecs[10] = '{1'b0, 1'b1, 4'b0000,     0,     0, 4'b0000, 4'b0100, -2048};
    vecs[11] = '{1'b0, 1'b1, 4'b1010,   100,    -1, 4'b1000, 4'b0000,     0};
    vecs[12] = '{1'b0, 1'b1, 4'b1010,   100,    -1, 4'b0010, 4'b1000,    99};
    vecs[13] = '{1'b0, 1'b1, 4'b1010,   100,    -1, 4'b1000, 4'b0010,    99};
    vecs[14] = '{1'b0, 1'b1, 4'b1010,   100,    -1, 4'b0010, 4'b1000,    99};
    vecs[15] = '{1'b0, 1'b1, 4'b0000,     0,     0, 4'b0000, 4'b0010,    99};
    vecs[16] = '{1'b0, 1'b1, 4'b0000,     0,     0, 4'b0000, 4'b0000,     0};
    vecs[17] = '{1'b0, 1'b0, 4'b1111,     0,     0, 4'b0000, 4'b0000,     0};
    vecs[18] = '{1'b0, 1'b1, 4'b0000,     0,     0, 4'b0000, 4'b0000,     0};

    reset = 1'b1; enable = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    // Let the first reset edge establish known state before comparing.
    @(posedge clk);
    #1;

    // Table: reset to first grant, streaming requester, fair rotation.
    for (int r = 0; r < 19; r++) begin
      reset = vecs[r].rst; enable = vecs[r].en; req_valid = vecs[r].valid;
      for (int i = 0; i < N; i++) begin
        req_a[i*W +: W] = W'(vecs[r].a);
        req_b[i*W +: W] = W'(vecs[r].b);
      end
      step();
      check($sformatf("vec%0d_ready", r), obs_ready1, vecs[r].exp_ready);
      check($sformatf("vec%0d_rsp", r), obs_rsp1, vecs[r].exp_rsp);
      if (vecs[r].exp_rsp != 0) check($sformatf("vec%0d_y", r), obs_y1, vecs[r].exp_y);
    end

    // Enable gating with two ops in flight (ADD_LAT=3 instance).
    req_valid = '0; step(); step();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'($urandom);
      req_b[i*W +: W] = W'($urandom);
    end
    enable = 1'b1; req_valid = '1;
    step(); step();
    enable = 1'b0;
    step();
    check("gate_ready", obs_ready3, 0);
    n_rsp = 0; last_rsp = -1; busy_fall = -1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      if (obs_rsp3 != 0) begin
        n_rsp++;
        last_rsp = k;
      end
      if (!obs_busy3 && busy_fall < 0) busy_fall = k;
    end
    check("gate_rsp_count", n_rsp, 2);
    check("gate_last_rsp", last_rsp, 2);
    check("gate_busy_fall", busy_fall, 3);

    // Reset with three ops in flight (ADD_LAT=3 instance).
    enable = 1'b1; req_valid = '1;
    step(); step(); step();
    reset = 1'b1;
    step();
    check("rst_ready", obs_ready3, 0);
    reset = 1'b0; req_valid = 4'b0110;
    step();
    check("rst_first_grant", obs_ready3, 4'b0010);
    check("rst_no_rsp_l3", obs_rsp3, 0);
    check("rst_no_rsp_l1", obs_rsp1, 0);
    check("rst_busy", obs_busy3, 0);
    req_valid = '0;
    n_rsp = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (obs_rsp3 != 0) begin
        n_rsp++;
        check("rst_rsp_owner", obs_rsp3, 4'b0010);
      end
    end
    check("rst_rsp_count", n_rsp, 1);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(39) == 0);
      enable    = ($urandom_range(7) != 0);
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(7))
          0:       req_a[i*W +: W] = W'(1023);
          1:       req_a[i*W +: W] = W'(-1024);
          default: req_a[i*W +: W] = W'($urandom);
        endcase
        case ($urandom_range(7))
          0:       req_b[i*W +: W] = W'(1023);
          1:       req_b[i*W +: W] = W'(-1024);
          default: req_b[i*W +: W] = W'($urandom);
        endcase
      end
      step();
    end

    // Idle operand ports.
    reset = 1'b0; enable = 1'b1; req_valid = '0;
    for (int k = 0; k < 5; k++) step();
    check("idle_add_a", obs_adda1, 0);
    check("idle_add_b", obs_addb1, 0);
    check("idle_ready", obs_ready1, 0);
    check("idle_busy_l1", obs_busy1, 0);
    check("idle_busy_l3", obs_busy3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
